// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the MEM-stage data-memory port arbiter: FSM states, transaction
// owner and the latched request payload.
package dmem_port_arbiter_pkg;

  localparam int unsigned BUS_W = 32;

  typedef logic [BUS_W-1:0] bus32_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } dmem_arb_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } dmem_owner_t;

  typedef struct packed {
    logic        we;
    bus32_t      addr;
    bus32_t      wdata;
    dmem_owner_t owner;
  } dmem_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the load unit and the store-buffer drain.
// Loads win by default; a store that keeps losing is forced through after STARVE_MAX losses.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        ld_req_valid_i,
  output logic        ld_req_ready_o,
  input  logic [31:0] ld_addr_i,
  output logic        ld_rsp_valid_o,
  output logic [31:0] ld_rsp_data_o,
  input  logic        st_req_valid_i,
  output logic        st_req_ready_o,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  dmem_arb_state_t  r_state;
  dmem_arb_state_t  w_state_nxt;
  dmem_req_t        r_req;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_ld_rsp_valid;
  bus32_t           r_ld_rsp_data;
  logic             w_ld_grant;
  logic             w_st_grant;
  logic             w_rsp_done;

  // Grant and next-state: arbitration happens only while the port is idle.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_grant  = 1'b0;
    w_st_grant  = 1'b0;
    case (r_state)
      IDLE: begin
        if (st_req_valid_i && (!ld_req_valid_i || (r_starve_cnt == CNT_MAX))) begin
          w_st_grant = 1'b1;
        end else if (ld_req_valid_i) begin
          w_ld_grant = 1'b1;
        end
        if (w_ld_grant || w_st_grant) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready_i) begin
          w_state_nxt = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_rsp_done = (r_state == WAIT_RSP) && mem_rsp_valid_i;

  // FSM, request payload, starvation counter and load response.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state        <= IDLE;
      r_req          <= '{we: 1'b0, addr: '0, wdata: '0, owner: NONE};
      r_starve_cnt   <= '0;
      r_ld_rsp_valid <= 1'b0;
      r_ld_rsp_data  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ld_rsp_valid <= 1'b0;
      if (w_st_grant) begin
        r_req        <= '{we: 1'b1, addr: st_addr_i, wdata: st_data_i, owner: STORE};
        r_starve_cnt <= '0;
      end else if (w_ld_grant) begin
        r_req <= '{we: 1'b0, addr: ld_addr_i, wdata: '0, owner: LOAD};
        if (st_req_valid_i && (r_starve_cnt != CNT_MAX)) begin
          r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
      end
      // Store acks are absorbed here; only load data goes back upstream.
      if (w_rsp_done) begin
        r_req.owner <= NONE;
        if (r_req.owner == LOAD) begin
          r_ld_rsp_valid <= 1'b1;
          r_ld_rsp_data  <= mem_rdata_i;
        end
      end
    end
  end

  // Ready is gated by reset so nothing handshakes while the port is held in reset.
  assign ld_req_ready_o  = w_ld_grant && rstn_i;
  assign st_req_ready_o  = w_st_grant && rstn_i;
  assign mem_req_valid_o = (r_state == REQ);
  assign mem_we_o        = r_req.we;
  assign mem_addr_o      = r_req.addr;
  assign mem_wdata_o     = r_req.wdata;
  assign ld_rsp_valid_o  = r_ld_rsp_valid;
  assign ld_rsp_data_o   = r_ld_rsp_data;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: single-requester vector table plus hand-written
// arbitration, starvation, back-pressure and mid-transaction reset sequences.
module tb_dmem_port_arbiter;

  logic        clk_i;
  logic        rstn_i;
  logic        ld_req_valid_i;
  logic        ld_req_ready_o;
  logic [31:0] ld_addr_i;
  logic        ld_rsp_valid_o;
  logic [31:0] ld_rsp_data_o;
  logic        st_req_valid_i;
  logic        st_req_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rdata_i;

  int checks;
  int failures;

  typedef struct {
    logic        is_st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic        exp_rsp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[4];

  dmem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .ld_req_valid_i (ld_req_valid_i),
    .ld_req_ready_o (ld_req_ready_o),
    .ld_addr_i      (ld_addr_i),
    .ld_rsp_valid_o (ld_rsp_valid_o),
    .ld_rsp_data_o  (ld_rsp_data_o),
    .st_req_valid_i (st_req_valid_i),
    .st_req_ready_o (st_req_ready_o),
    .st_addr_i      (st_addr_i),
    .st_data_i      (st_data_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Starts at the negedge after a handshake; 0-wait memory, ends at the next IDLE negedge.
  task automatic serve(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [31:0] rdata);
    mem_req_ready_i = 1'b1;
    #1;
    chk1({tag, "_req_valid"}, mem_req_valid_o, 1'b1);
    chk1({tag, "_we"}, mem_we_o, exp_we);
    chk32({tag, "_addr"}, mem_addr_o, exp_addr);
    chk32({tag, "_wdata"}, mem_wdata_o, exp_wdata);
    chk1({tag, "_ready_busy1"}, ld_req_ready_o | st_req_ready_o, 1'b0);
    tick();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = rdata;
    #1;
    chk1({tag, "_req_valid_wait"}, mem_req_valid_o, 1'b0);
    chk1({tag, "_ready_busy2"}, ld_req_ready_o | st_req_ready_o, 1'b0);
    chk1({tag, "_rsp_early"}, ld_rsp_valid_o, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b0;
    mem_rdata_i     = '0;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    ld_req_valid_i = !v.is_st;
    st_req_valid_i = v.is_st;
    ld_addr_i      = v.addr;
    st_addr_i      = v.addr;
    st_data_i      = v.wdata;
    #1;
    chk1({tag, "_ld_ready"}, ld_req_ready_o, !v.is_st);
    chk1({tag, "_st_ready"}, st_req_ready_o, v.is_st);
    tick();
    ld_req_valid_i = 1'b0;
    st_req_valid_i = 1'b0;
    serve(tag, v.exp_we, v.addr, v.exp_wdata, v.rdata);
    #1;
    chk1({tag, "_rsp_valid"}, ld_rsp_valid_o, v.exp_rsp);
    if (v.exp_rsp) chk32({tag, "_rsp_data"}, ld_rsp_data_o, v.exp_data);
    tick();
    chk1({tag, "_rsp_pulse_end"}, ld_rsp_valid_o, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_req_valid"}, mem_req_valid_o, 1'b0);
    chk1({tag, "_we"}, mem_we_o, 1'b0);
    chk32({tag, "_addr"}, mem_addr_o, 32'h0);
    chk32({tag, "_wdata"}, mem_wdata_o, 32'h0);
    chk1({tag, "_rsp_valid"}, ld_rsp_valid_o, 1'b0);
    chk32({tag, "_rsp_data"}, ld_rsp_data_o, 32'h0);
    chk1({tag, "_ld_ready"}, ld_req_ready_o, 1'b0);
    chk1({tag, "_st_ready"}, st_req_ready_o, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{1'b0, 32'h1000_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h1000_0004, 32'hCAFE_BABE, 32'h1234_5678, 1'b1, 32'hCAFE_BABE, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFF};

    rstn_i          = 1'b0;
    ld_req_valid_i  = 1'b1;
    st_req_valid_i  = 1'b1;
    ld_addr_i       = 32'h1111_1111;
    st_addr_i       = 32'h2222_2222;
    st_data_i       = 32'h3333_3333;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rdata_i     = '0;

    @(negedge clk_i);
    #1;
    chk_all_zero("reset");
    ld_req_valid_i = 1'b0;
    st_req_valid_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Load and store together: load first, store granted once the load drops.
    ld_req_valid_i = 1'b1;
    ld_addr_i      = 32'h1000_0100;
    st_req_valid_i = 1'b1;
    st_addr_i      = 32'h1000_0200;
    st_data_i      = 32'h0BAD_F00D;
    #1;
    chk1("both_ld_ready", ld_req_ready_o, 1'b1);
    chk1("both_st_ready", st_req_ready_o, 1'b0);
    tick();
    ld_req_valid_i = 1'b0;
    serve("both_ld", 1'b0, 32'h1000_0100, 32'h0, 32'h0000_1234);
    #1;
    chk1("both_ld_rsp_valid", ld_rsp_valid_o, 1'b1);
    chk32("both_ld_rsp_data", ld_rsp_data_o, 32'h0000_1234);
    chk1("both_st_ready_after", st_req_ready_o, 1'b1);
    tick();
    st_req_valid_i = 1'b0;
    serve("both_st", 1'b1, 32'h1000_0200, 32'h0BAD_F00D, 32'h0);
    #1;
    chk1("both_st_no_rsp", ld_rsp_valid_o, 1'b0);

    // Starvation: four loads win, the fifth arbitration goes to the store, then loads resume.
    ld_req_valid_i = 1'b1;
    ld_addr_i      = 32'h2000_0000;
    st_req_valid_i = 1'b1;
    st_addr_i      = 32'h3000_0000;
    st_data_i      = 32'h5A5A_5A5A;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk1($sformatf("starve%0d_ld_ready", k), ld_req_ready_o, k != 4);
      chk1($sformatf("starve%0d_st_ready", k), st_req_ready_o, k == 4);
      tick();
      if (k == 4) begin
        serve($sformatf("starve%0d", k), 1'b1, 32'h3000_0000, 32'h5A5A_5A5A, 32'hA000_0000 + 32'(k));
      end else begin
        serve($sformatf("starve%0d", k), 1'b0, 32'h2000_0000, 32'h0, 32'hA000_0000 + 32'(k));
      end
      #1;
      chk1($sformatf("starve%0d_rsp_valid", k), ld_rsp_valid_o, k != 4);
      if (k != 4) chk32($sformatf("starve%0d_rsp_data", k), ld_rsp_data_o, 32'hA000_0000 + 32'(k));
    end
    ld_req_valid_i = 1'b0;
    st_req_valid_i = 1'b0;
    tick();

    // Memory back-pressure: request held stable for three cycles, nobody else accepted.
    ld_req_valid_i = 1'b1;
    ld_addr_i      = 32'h4000_0010;
    #1;
    chk1("stall_ld_ready", ld_req_ready_o, 1'b1);
    tick();
    ld_req_valid_i = 1'b0;
    st_req_valid_i = 1'b1;
    st_addr_i      = 32'h4000_0020;
    st_data_i      = 32'h7777_0000;
    for (int s = 0; s < 3; s++) begin
      mem_req_ready_i = 1'b0;
      #1;
      chk1($sformatf("stall%0d_req_valid", s), mem_req_valid_o, 1'b1);
      chk32($sformatf("stall%0d_addr", s), mem_addr_o, 32'h4000_0010);
      chk1($sformatf("stall%0d_we", s), mem_we_o, 1'b0);
      chk32($sformatf("stall%0d_wdata", s), mem_wdata_o, 32'h0);
      chk1($sformatf("stall%0d_readies", s), ld_req_ready_o | st_req_ready_o, 1'b0);
      tick();
    end
    serve("stall", 1'b0, 32'h4000_0010, 32'h0, 32'h5555_AAAA);
    #1;
    chk1("stall_rsp_valid", ld_rsp_valid_o, 1'b1);
    chk32("stall_rsp_data", ld_rsp_data_o, 32'h5555_AAAA);
    chk1("stall_st_ready", st_req_ready_o, 1'b1);
    tick();
    st_req_valid_i = 1'b0;
    serve("stall_st", 1'b1, 32'h4000_0020, 32'h7777_0000, 32'h0);

    // Reset during WAIT_RSP, then a stale response after release.
    ld_req_valid_i = 1'b1;
    ld_addr_i      = 32'h6000_0000;
    #1;
    chk1("rst_ld_ready", ld_req_ready_o, 1'b1);
    tick();
    ld_req_valid_i  = 1'b0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    ld_req_valid_i  = 1'b1;
    #1;
    rstn_i = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick();
    ld_req_valid_i = 1'b0;
    rstn_i         = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = 32'h9999_9999;
    tick();
    mem_rsp_valid_i = 1'b0;
    mem_rdata_i     = '0;
    #1;
    chk1("late_rsp_valid", ld_rsp_valid_o, 1'b0);
    chk1("late_req_valid", mem_req_valid_o, 1'b0);
    tick();
    chk1("late_rsp_valid2", ld_rsp_valid_o, 1'b0);
    chk32("late_rsp_data", ld_rsp_data_o, 32'h0);

    run_vec("post_rst", vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
